id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of operands, immediate and forwarded results.
REQ-002 SHALL have ports clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports stall_i in 1 hold contents; flush_i in 1 load bubble; valid_i in 1 ID instruction valid.
REQ-004 SHALL have ports RS1data_i, RS2data_i, imm_i in XLEN register-file reads and immediate; rs1_addr_i, rs2_addr_i, rd_addr_i in 5 ID register indices.
REQ-005 SHALL have ports ALUCtrl_i in 3 ALU op code; ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i in 1 each, ID control.
REQ-006 SHALL have ports EXMEM_RegWrite_i in 1, EXMEM_rd_i in 5, EXMEM_data_i in XLEN; MEMWB_RegWrite_i in 1, MEMWB_rd_i in 5, MEMWB_data_i in XLEN, forwarding sources.
REQ-007 SHALL have ports data1_o, data2_o out XLEN ALU operands; store_data_o out XLEN memory write data; ALUCtrl_o out 3; rd_addr_o out 5.
REQ-008 SHALL have ports valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o out 1 each; hazard_o out 1 load-use stall request to ID.

Function
REQ-009 SHALL update all state registers on rising clk_i with priority rst_i > flush_i > stall_i > load.
REQ-010 SHALL on load capture every *_i field of ID (RS1data_i through MemWrite_i, valid_i) into the matching registered field; latency exactly one cycle.
REQ-011 SHALL on stall_i=1 (flush_i=0) hold every registered field unchanged.
REQ-012 SHALL on flush_i=1, regardless of stall_i, clear valid and all five control bits to 0, all data and index fields to 0.
REQ-013 SHALL force RegWrite_o, MemRead_o, MemWrite_o to 0 whenever registered valid is 0, even if registered control bits are 1.
REQ-014 SHALL derive forwarded rs1 value combinationally: EXMEM_data_i if EXMEM_RegWrite_i and EXMEM_rd_i!=0 and equals registered rs1; else MEMWB_data_i if MEMWB_RegWrite_i and MEMWB_rd_i!=0 and equals registered rs1; else registered RS1data.
REQ-015 SHALL derive forwarded rs2 value identically from registered rs2; EX/MEM wins when both sources match.
REQ-016 SHALL drive data1_o = forwarded rs1; data2_o = registered imm when registered ALUSrc=1, else forwarded rs2; store_data_o = forwarded rs2 always.
REQ-017 SHALL never forward for index x0; x0 operand passes registered RS data.
REQ-018 SHALL drive hazard_o = valid_o & MemRead_o & (rd_addr_o!=0) & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i), combinational, independent of valid_i.
REQ-019 SHALL keep forwarding and hazard_o evaluation active during stall, tracking changing EX/MEM and MEM/WB inputs.

Reset
REQ-020 SHALL on rst_i=1 immediately, without clock, clear all registered fields to 0, so valid_o, all controls, hazard_o, ALUCtrl_o, rd_addr_o read 0 and data outputs reflect zeroed registers plus live forwarding.
REQ-021 SHALL resume normal load on first rising clk_i after rst_i deasserts; reset mid-stall or mid-flush discards held instruction.

Configuration
REQ-022 SHALL with macro ID_EX_FORWARD_EN defined implement REQ-014/015/019 forwarding.
REQ-023 SHALL with ID_EX_FORWARD_EN undefined use registered RS1data/RS2data directly (forwarding inputs ignored), all other behaviour including hazard_o unchanged.

Verification
REQ-024 SHALL cover: load RS1=5, RS2=7, ALUSrc=0, ALUCtrl=000, valid=1 -> next cycle data1_o=5, data2_o=7, valid_o=1.
REQ-025 SHALL cover: registered rs1=3, EXMEM rd=3 data=0x11, MEMWB rd=3 data=0x22, both RegWrite=1 -> data1_o=0x11; drop EXMEM RegWrite -> 0x22; rd=0 on both -> registered RS1data.
REQ-026 SHALL cover: ALUSrc=1, imm=0xFFFFFFF0, rs2 forwarded 0x9 -> data2_o=0xFFFFFFF0, store_data_o=0x9.
REQ-027 SHALL cover: registered MemRead=1, rd=4, ID rs2_addr_i=4 -> hazard_o=1; apply stall_i 1 cycle -> contents held; flush_i with stall_i -> valid_o=0, MemWrite_o=0, hazard_o=0.
REQ-028 SHALL cover: assert rst_i between clock edges with valid_o=1, RegWrite_o=1 -> both 0 before next edge; without ID_EX_FORWARD_EN, REQ-025 stimulus -> data1_o=registered RS1data.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_reg_if
// Bundle of every non-clock/reset signal of the ID/EX pipeline register.
//
// Signal groups
//   ID side (into the register) : stall_i, flush_i, valid_i, RS1data_i,
//                                 RS2data_i, imm_i, rs1_addr_i, rs2_addr_i,
//                                 rd_addr_i, ALUCtrl_i, ALUSrc_i, RegWrite_i,
//                                 MemtoReg_i, MemRead_i, MemWrite_i
//   Forwarding sources          : EXMEM_RegWrite_i, EXMEM_rd_i, EXMEM_data_i,
//                                 MEMWB_RegWrite_i, MEMWB_rd_i, MEMWB_data_i
//   EX side (out of register)   : data1_o, data2_o, store_data_o, ALUCtrl_o,
//                                 rd_addr_o, valid_o, RegWrite_o, MemtoReg_o,
//                                 MemRead_o, MemWrite_o, hazard_o
//
// Modports
//   master : the surrounding pipeline, drives *_i and observes *_o
//   slave  : the ID/EX register itself
// ---------------------------------------------------------------------------
interface id_ex_reg_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            flush_i;
    logic            valid_i;
    logic [XLEN-1:0] RS1data_i;
    logic [XLEN-1:0] RS2data_i;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic [4:0]      rd_addr_i;
    logic [2:0]      ALUCtrl_i;
    logic            ALUSrc_i;
    logic            RegWrite_i;
    logic            MemtoReg_i;
    logic            MemRead_i;
    logic            MemWrite_i;

    logic            EXMEM_RegWrite_i;
    logic [4:0]      EXMEM_rd_i;
    logic [XLEN-1:0] EXMEM_data_i;
    logic            MEMWB_RegWrite_i;
    logic [4:0]      MEMWB_rd_i;
    logic [XLEN-1:0] MEMWB_data_i;

    logic [XLEN-1:0] data1_o;
    logic [XLEN-1:0] data2_o;
    logic [XLEN-1:0] store_data_o;
    logic [2:0]      ALUCtrl_o;
    logic [4:0]      rd_addr_o;
    logic            valid_o;
    logic            RegWrite_o;
    logic            MemtoReg_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic            hazard_o;

    modport master (
        output stall_i, flush_i, valid_i, RS1data_i, RS2data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, ALUCtrl_i, ALUSrc_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
               EXMEM_RegWrite_i, EXMEM_rd_i, EXMEM_data_i,
               MEMWB_RegWrite_i, MEMWB_rd_i, MEMWB_data_i,
        input  data1_o, data2_o, store_data_o, ALUCtrl_o, rd_addr_o,
               valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               hazard_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, RS1data_i, RS2data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, ALUCtrl_i, ALUSrc_i,
               RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
               EXMEM_RegWrite_i, EXMEM_rd_i, EXMEM_data_i,
               MEMWB_RegWrite_i, MEMWB_rd_i, MEMWB_data_i,
        output data1_o, data2_o, store_data_o, ALUCtrl_o, rd_addr_o,
               valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               hazard_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with operand forwarding and load-use detection.
//
// Ports
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset, clears every registered field
//   bus   : id_ex_reg_if.slave, ID-side fields, forwarding sources and the
//           EX-side outputs (see id_ex_reg_if.sv)
//
// Update priority on each rising edge: reset > flush > stall > load.
//
// Configuration
//   ID_EX_FORWARD_EN : when defined, EX/MEM and MEM/WB results are
//                      forwarded onto the operands; when undefined the
//                      registered register-file values are used directly.
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_reg_if.slave    bus
);

    logic            r_valid;
    logic [XLEN-1:0] r_rs1Data;
    logic [XLEN-1:0] r_rs2Data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1Addr;
    logic [4:0]      r_rs2Addr;
    logic [4:0]      r_rdAddr;
    logic [2:0]      r_aluCtrl;
    logic            r_aluSrc;
    logic            r_regWrite;
    logic            r_memtoReg;
    logic            r_memRead;
    logic            r_memWrite;

    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic            w_memReadQual;

    // Pipeline register. Flush loads a bubble (everything zero) even when
    // stall is also asserted, so a squashed instruction can never be held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_rs1Data  <= '0;
            r_rs2Data  <= '0;
            r_imm      <= '0;
            r_rs1Addr  <= 5'd0;
            r_rs2Addr  <= 5'd0;
            r_rdAddr   <= 5'd0;
            r_aluCtrl  <= 3'd0;
            r_aluSrc   <= 1'b0;
            r_regWrite <= 1'b0;
            r_memtoReg <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else if (bus.flush_i) begin
            r_valid    <= 1'b0;
            r_rs1Data  <= '0;
            r_rs2Data  <= '0;
            r_imm      <= '0;
            r_rs1Addr  <= 5'd0;
            r_rs2Addr  <= 5'd0;
            r_rdAddr   <= 5'd0;
            r_aluCtrl  <= 3'd0;
            r_aluSrc   <= 1'b0;
            r_regWrite <= 1'b0;
            r_memtoReg <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else if (!bus.stall_i) begin
            r_valid    <= bus.valid_i;
            r_rs1Data  <= bus.RS1data_i;
            r_rs2Data  <= bus.RS2data_i;
            r_imm      <= bus.imm_i;
            r_rs1Addr  <= bus.rs1_addr_i;
            r_rs2Addr  <= bus.rs2_addr_i;
            r_rdAddr   <= bus.rd_addr_i;
            r_aluCtrl  <= bus.ALUCtrl_i;
            r_aluSrc   <= bus.ALUSrc_i;
            r_regWrite <= bus.RegWrite_i;
            r_memtoReg <= bus.MemtoReg_i;
            r_memRead  <= bus.MemRead_i;
            r_memWrite <= bus.MemWrite_i;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger result so it takes precedence over MEM/WB.
    // Index x0 is hardwired zero and must never pick up a forwarded value.
    always_comb begin
        w_fwd1 = r_rs1Data;
        if (bus.EXMEM_RegWrite_i && (bus.EXMEM_rd_i != 5'd0) &&
            (bus.EXMEM_rd_i == r_rs1Addr))
            w_fwd1 = bus.EXMEM_data_i;
        else if (bus.MEMWB_RegWrite_i && (bus.MEMWB_rd_i != 5'd0) &&
                 (bus.MEMWB_rd_i == r_rs1Addr))
            w_fwd1 = bus.MEMWB_data_i;
    end

    always_comb begin
        w_fwd2 = r_rs2Data;
        if (bus.EXMEM_RegWrite_i && (bus.EXMEM_rd_i != 5'd0) &&
            (bus.EXMEM_rd_i == r_rs2Addr))
            w_fwd2 = bus.EXMEM_data_i;
        else if (bus.MEMWB_RegWrite_i && (bus.MEMWB_rd_i != 5'd0) &&
                 (bus.MEMWB_rd_i == r_rs2Addr))
            w_fwd2 = bus.MEMWB_data_i;
    end
`else
    assign w_fwd1 = r_rs1Data;
    assign w_fwd2 = r_rs2Data;
`endif

    assign bus.data1_o      = w_fwd1;
    assign bus.data2_o      = r_aluSrc ? r_imm : w_fwd2;
    assign bus.store_data_o = w_fwd2;
    assign bus.ALUCtrl_o    = r_aluCtrl;
    assign bus.rd_addr_o    = r_rdAddr;
    assign bus.valid_o      = r_valid;
    assign bus.MemtoReg_o   = r_memtoReg;

    // Side-effecting controls of a bubble must stay inert even if stale
    // control bits were captured alongside valid=0.
    assign bus.RegWrite_o   = r_valid & r_regWrite;
    assign bus.MemRead_o    = r_valid & r_memRead;
    assign bus.MemWrite_o   = r_valid & r_memWrite;

    // Load-use hazard: the load in EX cannot forward in time to the
    // instruction currently decoding in ID, whatever its valid bit says.
    assign w_memReadQual    = r_valid & r_memRead & (r_rdAddr != 5'd0);
    assign bus.hazard_o     = w_memReadQual &
                              ((r_rdAddr == bus.rs1_addr_i) ||
                               (r_rdAddr == bus.rs2_addr_i));

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
// Self-checking bench for id_ex_reg: directed scenarios followed by
// randomized traffic compared against an instruction-level reference model.
// Works with or without ID_EX_FORWARD_EN defined.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int XLEN = 32;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    id_ex_reg_if #(.XLEN(XLEN)) bus();

    id_ex_reg #(.XLEN(XLEN)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // One decoded instruction as it sits in the EX stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  aluCtrl;
        logic        aluSrc;
        logic        regWrite;
        logic        memtoReg;
        logic        memRead;
        logic        memWrite;
    } instr_t;

    instr_t model;
    int vectors     = 0;
    int miscompares = 0;

    task automatic applyStimulus(input instr_t s);
        bus.valid_i    = s.valid;
        bus.RS1data_i  = s.rs1Data;
        bus.RS2data_i  = s.rs2Data;
        bus.imm_i      = s.imm;
        bus.rs1_addr_i = s.rs1;
        bus.rs2_addr_i = s.rs2;
        bus.rd_addr_i  = s.rd;
        bus.ALUCtrl_i  = s.aluCtrl;
        bus.ALUSrc_i   = s.aluSrc;
        bus.RegWrite_i = s.regWrite;
        bus.MemtoReg_i = s.memtoReg;
        bus.MemRead_i  = s.memRead;
        bus.MemWrite_i = s.memWrite;
    endtask

    task automatic setForward(input logic exRw, input logic [4:0] exRd,
                              input logic [31:0] exData, input logic mwRw,
                              input logic [4:0] mwRd, input logic [31:0] mwData);
        bus.EXMEM_RegWrite_i = exRw;
        bus.EXMEM_rd_i       = exRd;
        bus.EXMEM_data_i     = exData;
        bus.MEMWB_RegWrite_i = mwRw;
        bus.MEMWB_rd_i       = mwRd;
        bus.MEMWB_data_i     = mwData;
    endtask

    function automatic instr_t sampleId();
        instr_t s;
        s.valid    = bus.valid_i;
        s.rs1Data  = bus.RS1data_i;
        s.rs2Data  = bus.RS2data_i;
        s.imm      = bus.imm_i;
        s.rs1      = bus.rs1_addr_i;
        s.rs2      = bus.rs2_addr_i;
        s.rd       = bus.rd_addr_i;
        s.aluCtrl  = bus.ALUCtrl_i;
        s.aluSrc   = bus.ALUSrc_i;
        s.regWrite = bus.RegWrite_i;
        s.memtoReg = bus.MemtoReg_i;
        s.memRead  = bus.MemRead_i;
        s.memWrite = bus.MemWrite_i;
        return s;
    endfunction

    function automatic instr_t randInstr();
        instr_t s;
        s.valid    = 1'($urandom);
        s.rs1Data  = $urandom;
        s.rs2Data  = $urandom;
        s.imm      = $urandom;
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.rd       = 5'($urandom_range(0, 3));
        s.aluCtrl  = 3'($urandom);
        s.aluSrc   = 1'($urandom);
        s.regWrite = 1'($urandom);
        s.memtoReg = 1'($urandom);
        s.memRead  = 1'($urandom);
        s.memWrite = 1'($urandom);
        return s;
    endfunction

    // Value an operand should have in EX: the newest in-flight write to its
    // register wins; x0 is never overwritten.
    function automatic logic [31:0] expFwd(input logic [4:0] idx, input logic [31:0] held);
`ifdef ID_EX_FORWARD_EN
        if (idx == 5'd0) return held;
        if (bus.EXMEM_RegWrite_i && bus.EXMEM_rd_i == idx) return bus.EXMEM_data_i;
        if (bus.MEMWB_RegWrite_i && bus.MEMWB_rd_i == idx) return bus.MEMWB_data_i;
`endif
        return held;
    endfunction

    // Rising edge plus reference-model update, returns on the falling edge.
    task automatic advance();
        @(posedge clk_i);
        if (rst_i || bus.flush_i) model = '0;
        else if (!bus.stall_i)    model = sampleId();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        instr_t s;
        s = '0;
        applyStimulus(s);
        setForward(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        rst_i = 1'b1;
        model = '0;
        #1;
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.hazard_o !== 1'b0 ||
            bus.ALUCtrl_o !== 3'd0 || bus.rd_addr_o !== 5'd0 || bus.data1_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: valid=%b rw=%b hz=%b alu=%h rd=%h d1=%h, required all zero",
                     bus.valid_o, bus.RegWrite_o, bus.hazard_o, bus.ALUCtrl_o, bus.rd_addr_o, bus.data1_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_basic_load();
        instr_t s;
        s = '0;
        s.valid = 1'b1; s.rs1Data = 32'd5; s.rs2Data = 32'd7;
        s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd6; s.regWrite = 1'b1;
        applyStimulus(s);
        advance();
        applyStimulus('0);
        #1;
        vectors++;
        if (bus.data1_o !== 32'd5 || bus.data2_o !== 32'd7 || bus.valid_o !== 1'b1 ||
            bus.ALUCtrl_o !== 3'd0 || bus.rd_addr_o !== 5'd6) begin
            miscompares++;
            $display("[TB] FAIL basic_load: d1=%h d2=%h v=%b alu=%h rd=%h, required 5 7 1 0 6",
                     bus.data1_o, bus.data2_o, bus.valid_o, bus.ALUCtrl_o, bus.rd_addr_o);
        end
    endtask

    task automatic test_forwarding();
        instr_t s;
        s = '0;
        s.valid = 1'b1; s.rs1 = 5'd3; s.rs1Data = 32'hAA; s.rs2 = 5'd0; s.rs2Data = 32'h55;
        applyStimulus(s);
        advance();
        // Hold the instruction and scribble the ID inputs to prove the hold.
        bus.stall_i = 1'b1;
        applyStimulus(randInstr());
        setForward(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        #1;
        vectors++;
`ifdef ID_EX_FORWARD_EN
        if (bus.data1_o !== 32'h11) begin
`else
        if (bus.data1_o !== 32'hAA) begin
`endif
            miscompares++;
            $display("[TB] FAIL fwd_exmem_wins: got %h", bus.data1_o);
        end
        setForward(1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        #1;
        vectors++;
`ifdef ID_EX_FORWARD_EN
        if (bus.data1_o !== 32'h22) begin
`else
        if (bus.data1_o !== 32'hAA) begin
`endif
            miscompares++;
            $display("[TB] FAIL fwd_memwb: got %h", bus.data1_o);
        end
        setForward(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        #1;
        vectors++;
        if (bus.data1_o !== 32'hAA) begin
            miscompares++;
            $display("[TB] FAIL fwd_rd_zero: got %h required 000000aa", bus.data1_o);
        end
        // x0 operand must ignore a matching write to x0.
        vectors++;
        if (bus.store_data_o !== 32'h55) begin
            miscompares++;
            $display("[TB] FAIL fwd_x0_operand: got %h required 00000055", bus.store_data_o);
        end
        advance();
        #1;
        vectors++;
        if (bus.data1_o !== 32'hAA || bus.valid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_hold_data: d1=%h v=%b required 000000aa 1", bus.data1_o, bus.valid_o);
        end
        bus.stall_i = 1'b0;
        setForward(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_immediate();
        instr_t s;
        s = '0;
        s.valid = 1'b1; s.aluSrc = 1'b1; s.imm = 32'hFFFF_FFF0;
        s.rs2 = 5'd5; s.rs2Data = 32'h3;
        applyStimulus(s);
        setForward(1'b1, 5'd5, 32'h9, 1'b0, 5'd0, 32'd0);
        advance();
        #1;
        vectors++;
        if (bus.data2_o !== 32'hFFFF_FFF0) begin
            miscompares++;
            $display("[TB] FAIL imm_select: got %h required fffffff0", bus.data2_o);
        end
        vectors++;
`ifdef ID_EX_FORWARD_EN
        if (bus.store_data_o !== 32'h9) begin
`else
        if (bus.store_data_o !== 32'h3) begin
`endif
            miscompares++;
            $display("[TB] FAIL store_data: got %h", bus.store_data_o);
        end
        setForward(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_hazard();
        instr_t s;
        s = '0;
        s.valid = 1'b1; s.memRead = 1'b1; s.memWrite = 1'b1; s.rd = 5'd4;
        s.rs1 = 5'd1; s.rs2 = 5'd2;
        applyStimulus(s);
        advance();
        s = '0;
        s.valid = 1'b1; s.rs1 = 5'd9; s.rs2 = 5'd4; s.rd = 5'd9;
        applyStimulus(s);
        #1;
        vectors++;
        if (bus.hazard_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hazard_detect: got %b required 1", bus.hazard_o);
        end
        bus.stall_i = 1'b1;
        advance();
        #1;
        vectors++;
        if (bus.rd_addr_o !== 5'd4 || bus.MemRead_o !== 1'b1 || bus.hazard_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hazard_stall_hold: rd=%h mr=%b hz=%b required 04 1 1",
                     bus.rd_addr_o, bus.MemRead_o, bus.hazard_o);
        end
        bus.flush_i = 1'b1;
        advance();
        #1;
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.MemWrite_o !== 1'b0 || bus.hazard_o !== 1'b0 ||
            bus.rd_addr_o !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_over_stall: v=%b mw=%b hz=%b rd=%h required 0 0 0 00",
                     bus.valid_o, bus.MemWrite_o, bus.hazard_o, bus.rd_addr_o);
        end
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
    endtask

    task automatic test_valid_gate();
        instr_t s;
        s = '0;
        s.valid = 1'b0; s.regWrite = 1'b1; s.memRead = 1'b1; s.memWrite = 1'b1;
        s.memtoReg = 1'b1; s.rd = 5'd4;
        applyStimulus(s);
        advance();
        s.rs2 = 5'd4;
        applyStimulus(s);
        #1;
        vectors++;
        if (bus.RegWrite_o !== 1'b0 || bus.MemRead_o !== 1'b0 || bus.MemWrite_o !== 1'b0 ||
            bus.hazard_o !== 1'b0 || bus.MemtoReg_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL valid_gate: rw=%b mr=%b mw=%b hz=%b m2r=%b required 0 0 0 0 1",
                     bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.hazard_o, bus.MemtoReg_o);
        end
    endtask

    task automatic test_async_reset();
        instr_t s;
        s = '0;
        s.valid = 1'b1; s.regWrite = 1'b1; s.rd = 5'd7;
        applyStimulus(s);
        advance();
        #1;
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.RegWrite_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_load: v=%b rw=%b required 1 1", bus.valid_o, bus.RegWrite_o);
        end
        // Assert reset well before the next rising edge, with stall held.
        bus.stall_i = 1'b1;
        #2;
        rst_i = 1'b1;
        model = '0;
        #1;
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.rd_addr_o !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: v=%b rw=%b rd=%h required 0 0 00",
                     bus.valid_o, bus.RegWrite_o, bus.rd_addr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.stall_i = 1'b0;
        s.rd = 5'd8;
        applyStimulus(s);
        advance();
        #1;
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.rd_addr_o !== 5'd8) begin
            miscompares++;
            $display("[TB] FAIL post_reset_load: v=%b rd=%h required 1 08", bus.valid_o, bus.rd_addr_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] eD1, eD2, eSt;
        logic        eHz;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randInstr());
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.flush_i = ($urandom_range(0, 7) == 0);
            advance();
            // New forwarding sources and ID indices arrive between edges.
            setForward(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                       1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            bus.rs1_addr_i = 5'($urandom_range(0, 3));
            bus.rs2_addr_i = 5'($urandom_range(0, 3));
            #1;
            eD1 = expFwd(model.rs1, model.rs1Data);
            eSt = expFwd(model.rs2, model.rs2Data);
            eD2 = model.aluSrc ? model.imm : eSt;
            eHz = model.valid && model.memRead && model.rd != 5'd0 &&
                  (model.rd == bus.rs1_addr_i || model.rd == bus.rs2_addr_i);
            vectors++;
            if (bus.data1_o !== eD1 || bus.data2_o !== eD2 || bus.store_data_o !== eSt) begin
                miscompares++;
                $display("[TB] FAIL rand_data it%0d: d1=%h/%h d2=%h/%h st=%h/%h (got/required)",
                         i, bus.data1_o, eD1, bus.data2_o, eD2, bus.store_data_o, eSt);
            end
            vectors++;
            if (bus.valid_o !== model.valid || bus.ALUCtrl_o !== model.aluCtrl ||
                bus.rd_addr_o !== model.rd || bus.MemtoReg_o !== model.memtoReg) begin
                miscompares++;
                $display("[TB] FAIL rand_fields it%0d: v=%b/%b alu=%h/%h rd=%h/%h m2r=%b/%b (got/required)",
                         i, bus.valid_o, model.valid, bus.ALUCtrl_o, model.aluCtrl,
                         bus.rd_addr_o, model.rd, bus.MemtoReg_o, model.memtoReg);
            end
            vectors++;
            if (bus.RegWrite_o !== (model.valid & model.regWrite) ||
                bus.MemRead_o  !== (model.valid & model.memRead) ||
                bus.MemWrite_o !== (model.valid & model.memWrite) ||
                bus.hazard_o   !== eHz) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl it%0d: rw=%b mr=%b mw=%b hz=%b required %b %b %b %b",
                         i, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.hazard_o,
                         model.valid & model.regWrite, model.valid & model.memRead,
                         model.valid & model.memWrite, eHz);
            end
        end
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_forwarding();
        test_immediate();
        test_hazard();
        test_valid_gate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
